// File: rtl/tuner_phy_pkg.sv
// Shared types and constants for the tuner PHY control slice.
// Imported by the request arbiter and its round-robin picker.
package tuner_phy_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_TUNE = 2'd1,
        ARB_WAIT = 2'd2
    } tuner_req_arb_state_e;

    // Default requester slots when the arbiter fronts the standard three controllers.
    localparam int REQ_SEARCH = 0;
    localparam int REQ_LOCK   = 1;
    localparam int REQ_DITHER = 2;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tuner_rr_pick.sv
// Combinational round-robin selector: first set request strictly after ptr, with wrap.
// Returns a one-hot winner, its index, and whether any request was present.
module tuner_rr_pick
    import tuner_phy_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx,
    output logic               vld
);

    int               cand;
    logic [PTR_W-1:0] cidx;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = 0;
        cidx = '0;
        // Scan ptr+1 .. ptr+NUM_REQ so the last winner is considered last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            cidx = PTR_W'(cand);
            if ((gnt == '0) && req[cidx]) begin
                gnt[cidx] = 1'b1;
                idx       = cidx;
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/tuner_ctrl_req_arbiter.sv
// Shares one tuner PHY between NUM_REQ controllers for whole tune->commit transactions,
// with round-robin fairness, bounded ownership hold and a commit watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no owner; pick next requester round-robin
// ARB_TUNE | owner granted; forward its tune request to the PHY
// ARB_WAIT | tune accepted; wait for PHY commit, watchdog running
module tuner_ctrl_req_arbiter
    import tuner_phy_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int DAC_WIDTH   = 8,
    parameter int ADC_WIDTH   = 8,
    parameter int HOLD_MAX    = 16,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_tune_val,
    output logic [NUM_REQ-1:0]             o_req_tune_rdy,
    input  logic [NUM_REQ*DAC_WIDTH-1:0]   i_req_ring_tune,
    input  logic [NUM_REQ-1:0]             i_req_hold,
    output logic [NUM_REQ-1:0]             o_req_commit_val,
    input  logic [NUM_REQ-1:0]             i_req_commit_rdy,
    output logic [ADC_WIDTH-1:0]           o_req_pwr_commit,
    output logic [DAC_WIDTH-1:0]           o_req_ring_tune_commit,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_phy_tune_val,
    input  logic                           i_phy_tune_rdy,
    output logic [DAC_WIDTH-1:0]           o_phy_ring_tune,
    input  logic                           i_phy_commit_val,
    output logic                           o_phy_commit_rdy,
    input  logic [ADC_WIDTH-1:0]           i_phy_pwr_commit,
    input  logic [DAC_WIDTH-1:0]           i_phy_ring_tune_commit,
    output logic                           o_phy_refresh,
    output logic                           o_timeout
);

    localparam int PTR_W  = ptr_width(NUM_REQ);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int WDOG_W = $clog2(WDOG_CYCLES);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(NUM_REQ - 1);

    tuner_req_arb_state_e state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [WDOG_W-1:0]    wdog_cnt;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_vld;

    logic [DAC_WIDTH-1:0] owner_code;
    logic                 owner_tune_val;
    logic                 owner_commit_rdy;
    logic                 owner_hold;
    logic                 others_waiting;
    logic                 hold_ok;
    logic                 in_tune;
    logic                 in_wait;
    logic                 tune_fire;
    logic                 commit_fire;

    tuner_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req (i_req_tune_val),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // o_grant is one-hot (or zero), so OR-ing the selected slices is a clean mux.
    always_comb begin
        owner_code = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) begin
                owner_code = owner_code | i_req_ring_tune[k*DAC_WIDTH +: DAC_WIDTH];
            end
        end
    end

    assign owner_tune_val   = |(i_req_tune_val & o_grant);
    assign owner_commit_rdy = |(i_req_commit_rdy & o_grant);
    assign owner_hold       = |(i_req_hold & o_grant);
    assign others_waiting   = |(i_req_tune_val & ~o_grant);
    assign hold_ok          = owner_hold && ((hold_cnt < HOLD_LAST) || !others_waiting);

    assign in_tune = (state == ARB_TUNE);
    assign in_wait = (state == ARB_WAIT);

    assign o_phy_tune_val         = in_tune && owner_tune_val;
    assign o_phy_ring_tune        = in_tune ? owner_code : '0;
    assign o_req_tune_rdy         = (in_tune && i_phy_tune_rdy) ? o_grant : '0;

    assign o_req_commit_val       = (in_wait && i_phy_commit_val) ? o_grant : '0;
    assign o_phy_commit_rdy       = in_wait && owner_commit_rdy;
    assign o_req_pwr_commit       = in_wait ? i_phy_pwr_commit : '0;
    assign o_req_ring_tune_commit = in_wait ? i_phy_ring_tune_commit : '0;

    assign tune_fire   = o_phy_tune_val && i_phy_tune_rdy;
    assign commit_fire = in_wait && i_phy_commit_val && owner_commit_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ARB_IDLE;
            o_grant       <= '0;
            rr_ptr        <= PTR_INIT;
            hold_cnt      <= '0;
            wdog_cnt      <= '0;
            o_phy_refresh <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            o_phy_refresh <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        o_grant  <= pick_gnt;
                        rr_ptr   <= pick_idx;
                        hold_cnt <= '0;
                        state    <= ARB_TUNE;
                    end
                end
                ARB_TUNE: begin
                    if (tune_fire) begin
                        wdog_cnt <= WDOG_LOAD;
                        state    <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    // A commit landing on the expiry cycle still counts as a commit.
                    if (commit_fire) begin
                        if (hold_ok) begin
                            state <= ARB_TUNE;
                            if (hold_cnt != HOLD_LAST) begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end else begin
                            state   <= ARB_IDLE;
                            o_grant <= '0;
                        end
                    end else if (wdog_cnt == '0) begin
                        o_phy_refresh <= 1'b1;
                        o_timeout     <= 1'b1;
                        o_grant       <= '0;
                        state         <= ARB_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuner_ctrl_req_arbiter.sv
// Self-checking bench for tuner_ctrl_req_arbiter: vector table of transactions plus
// hand-written hold, watchdog, reset and commit-vs-expiry sequences.
module tb_tuner_ctrl_req_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int HM = 4;
    localparam int WD = 10;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    req_val;
    logic [N-1:0]    o_req_tune_rdy;
    logic [N*DW-1:0] req_tune;
    logic [N-1:0]    req_hold;
    logic [N-1:0]    o_req_commit_val;
    logic [N-1:0]    req_commit_rdy;
    logic [AW-1:0]   o_req_pwr_commit;
    logic [DW-1:0]   o_req_ring_tune_commit;
    logic [N-1:0]    o_grant;
    logic            o_phy_tune_val;
    logic            phy_tune_rdy;
    logic [DW-1:0]   o_phy_ring_tune;
    logic            phy_commit_val;
    logic            o_phy_commit_rdy;
    logic [AW-1:0]   phy_pwr;
    logic [DW-1:0]   phy_code;
    logic            o_phy_refresh;
    logic            o_timeout;

    always #5 i_clk = ~i_clk;

    tuner_ctrl_req_arbiter #(
        .NUM_REQ     (N),
        .DAC_WIDTH   (DW),
        .ADC_WIDTH   (AW),
        .HOLD_MAX    (HM),
        .WDOG_CYCLES (WD)
    ) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_req_tune_val         (req_val),
        .o_req_tune_rdy         (o_req_tune_rdy),
        .i_req_ring_tune        (req_tune),
        .i_req_hold             (req_hold),
        .o_req_commit_val       (o_req_commit_val),
        .i_req_commit_rdy       (req_commit_rdy),
        .o_req_pwr_commit       (o_req_pwr_commit),
        .o_req_ring_tune_commit (o_req_ring_tune_commit),
        .o_grant                (o_grant),
        .o_phy_tune_val         (o_phy_tune_val),
        .i_phy_tune_rdy         (phy_tune_rdy),
        .o_phy_ring_tune        (o_phy_ring_tune),
        .i_phy_commit_val       (phy_commit_val),
        .o_phy_commit_rdy       (o_phy_commit_rdy),
        .i_phy_pwr_commit       (phy_pwr),
        .i_phy_ring_tune_commit (phy_code),
        .o_phy_refresh          (o_phy_refresh),
        .o_timeout              (o_timeout)
    );

    typedef struct {
        logic [2:0]  val;
        logic [23:0] codes;
        int          tdelay;
        int          cdelay;
        logic [7:0]  pwr;
        logic [7:0]  ccode;
        logic [2:0]  exp_grant;
        logic [7:0]  exp_code;
    } vec_t;

    typedef struct {
        logic [2:0] grant;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    vec_t vecs[9];
    exp_t tune_q[$];
    exp_t commit_q[$];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   refresh_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard side: pop expectations when the DUT actually hands data over.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            if (o_phy_tune_val && phy_tune_rdy) begin
                if (tune_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tune_unexpected: got grant %0b code %0h with nothing queued",
                             o_grant, o_phy_ring_tune);
                end else begin
                    e = tune_q.pop_front();
                    check("tune_fire_grant", 32'(o_grant), 32'(e.grant));
                    check("tune_fire_code", 32'(o_phy_ring_tune), 32'(e.a));
                end
            end
            if (phy_commit_val && ((o_req_commit_val & req_commit_rdy) != '0)) begin
                if (commit_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got commit_val %0b with nothing queued",
                             o_req_commit_val);
                end else begin
                    e = commit_q.pop_front();
                    check("commit_owner", 32'(o_req_commit_val), 32'(e.grant));
                    check("commit_pwr", 32'(o_req_pwr_commit), 32'(e.a));
                    check("commit_code", 32'(o_req_ring_tune_commit), 32'(e.b));
                    check("commit_phy_rdy", 32'(o_phy_commit_rdy), 1);
                end
            end
            if (o_phy_refresh) refresh_cnt++;
        end
    end

    task automatic tune_phase(input logic [2:0] g, input logic [7:0] code,
                              input int tdelay, input bit clear_val);
        int   k;
        exp_t e;
        phy_tune_rdy = 1'b0;
        k = 0;
        while (o_grant == 3'b000 && k < 20) begin
            tick();
            k++;
        end
        check("grant", 32'(o_grant), 32'(g));
        e.grant = g;
        e.a     = code;
        e.b     = '0;
        tune_q.push_back(e);
        for (int i = 0; i < tdelay; i++) begin
            @(negedge i_clk);
            check("tune_rdy_gated", 32'(o_req_tune_rdy), 0);
            check("tune_val_fwd", 32'(o_phy_tune_val), 1);
            check("tune_code_fwd", 32'(o_phy_ring_tune), 32'(code));
            tick();
        end
        phy_tune_rdy = 1'b1;
        @(negedge i_clk);
        check("tune_rdy_owner", 32'(o_req_tune_rdy), 32'(g));
        tick();
        if (clear_val) req_val = req_val & ~g;
    endtask

    task automatic commit_phase(input logic [2:0] g, input int wwait, input int cdelay,
                                input logic [7:0] pwr, input logic [7:0] code);
        exp_t e;
        for (int i = 0; i < wwait; i++) tick();
        phy_commit_val = 1'b1;
        phy_pwr        = pwr;
        phy_code       = code;
        req_commit_rdy = ~g;
        e.grant = g;
        e.a     = pwr;
        e.b     = code;
        commit_q.push_back(e);
        for (int i = 0; i < cdelay; i++) begin
            @(negedge i_clk);
            check("commit_rdy_gated", 32'(o_phy_commit_rdy), 0);
            check("commit_val_owner_only", 32'(o_req_commit_val), 32'(g));
            check("tune_rdy_in_wait", 32'(o_req_tune_rdy), 0);
            tick();
        end
        req_commit_rdy = 3'b111;
        @(negedge i_clk);
        check("commit_pwr_fwd", 32'(o_req_pwr_commit), 32'(pwr));
        check("commit_code_fwd", 32'(o_req_ring_tune_commit), 32'(code));
        tick();
        phy_commit_val = 1'b0;
        req_commit_rdy = '0;
        phy_pwr        = '0;
        phy_code       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;

        //         val     codes         td cd pwr    ccode  grant   code
        vecs[0] = '{3'b101, 24'h332211, 0, 0, 8'h01, 8'h81, 3'b001, 8'h11};
        vecs[1] = '{3'b100, 24'h332211, 1, 1, 8'h02, 8'h82, 3'b100, 8'h33};
        vecs[2] = '{3'b111, 24'h665544, 0, 0, 8'h03, 8'h83, 3'b001, 8'h44};
        vecs[3] = '{3'b110, 24'h665544, 2, 0, 8'h04, 8'h84, 3'b010, 8'h55};
        vecs[4] = '{3'b101, 24'h998877, 0, 2, 8'h05, 8'h85, 3'b100, 8'h99};
        vecs[5] = '{3'b010, 24'h33A511, 3, 0, 8'h06, 8'h86, 3'b010, 8'hA5};
        vecs[6] = '{3'b011, 24'h0C0B0A, 0, 0, 8'h07, 8'h87, 3'b001, 8'h0A};
        vecs[7] = '{3'b010, 24'h0C0B0A, 0, 5, 8'h3C, 8'h42, 3'b010, 8'h0B};
        vecs[8] = '{3'b110, 24'hCCBBAA, 0, 0, 8'h09, 8'h89, 3'b100, 8'hCC};

        i_rst          = 1'b1;
        req_val        = 3'b111;
        req_tune       = 24'h332211;
        req_hold       = '0;
        req_commit_rdy = 3'b111;
        phy_tune_rdy   = 1'b1;
        phy_commit_val = 1'b1;
        phy_pwr        = 8'hFF;
        phy_code       = 8'hFF;
        repeat (3) @(negedge i_clk);
        check("rst_grant", 32'(o_grant), 0);
        check("rst_phy_tune_val", 32'(o_phy_tune_val), 0);
        check("rst_tune_rdy", 32'(o_req_tune_rdy), 0);
        check("rst_commit_val", 32'(o_req_commit_val), 0);
        check("rst_phy_commit_rdy", 32'(o_phy_commit_rdy), 0);
        check("rst_pwr_commit", 32'(o_req_pwr_commit), 0);
        check("rst_timeout", 32'(o_timeout), 0);
        check("rst_refresh", 32'(o_phy_refresh), 0);
        req_val        = '0;
        req_commit_rdy = '0;
        phy_tune_rdy   = 1'b0;
        phy_commit_val = 1'b0;
        phy_pwr        = '0;
        phy_code       = '0;
        tick();
        i_rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            req_val  = vecs[v].val;
            req_tune = vecs[v].codes;
            tune_phase(vecs[v].exp_grant, vecs[v].exp_code, vecs[v].tdelay, 1'b1);
            commit_phase(vecs[v].exp_grant, 0, vecs[v].cdelay, vecs[v].pwr, vecs[v].ccode);
        end
        check("table_no_refresh", 32'(refresh_cnt), 0);
        check("table_no_timeout", 32'(o_timeout), 0);

        // Holder req1 with req0 waiting: exactly HM back-to-back transactions.
        req_tune = 24'h332211;
        req_hold = 3'b010;
        req_val  = 3'b010;
        tune_phase(3'b010, 8'h22, 0, 1'b0);
        req_val = 3'b011;
        commit_phase(3'b010, 0, 0, 8'h10, 8'h90);
        for (int h = 1; h < HM; h++) begin
            check("hold_no_gap", 32'(o_grant), 32'(3'b010));
            tune_phase(3'b010, 8'h22, 0, h == HM - 1);
            commit_phase(3'b010, 0, 1, 8'(8'h10 + h), 8'(8'h90 + h));
        end
        req_hold = '0;
        tune_phase(3'b001, 8'h11, 0, 1'b1);
        commit_phase(3'b001, 0, 0, 8'h20, 8'hA0);

        // Lone holder keeps ownership past HM transactions.
        req_hold = 3'b100;
        req_val  = 3'b100;
        tune_phase(3'b100, 8'h33, 0, 1'b0);
        commit_phase(3'b100, 0, 0, 8'h30, 8'hB0);
        for (int h = 1; h <= HM; h++) begin
            check("lone_hold_no_gap", 32'(o_grant), 32'(3'b100));
            tune_phase(3'b100, 8'h33, 0, h == HM);
            if (h == HM) req_hold = '0;
            commit_phase(3'b100, 0, 0, 8'(8'h30 + h), 8'(8'hB0 + h));
        end

        // Watchdog: PHY never commits.
        req_val = 3'b001;
        tune_phase(3'b001, 8'h11, 0, 1'b1);
        seen = -1;
        for (int k = 1; k <= 30 && seen < 0; k++) begin
            @(negedge i_clk);
            if (o_phy_refresh) seen = k - 1;
        end
        check("wdog_refresh_delay", 32'(seen), WD);
        @(negedge i_clk);
        check("wdog_refresh_width", 32'(o_phy_refresh), 0);
        check("wdog_timeout_set", 32'(o_timeout), 1);
        check("wdog_grant_clear", 32'(o_grant), 0);
        tick();
        req_val = 3'b011;
        tune_phase(3'b010, 8'h22, 0, 1'b1);
        commit_phase(3'b010, 0, 0, 8'h44, 8'hC4);
        check("timeout_sticky", 32'(o_timeout), 1);
        check("wdog_refresh_count", 32'(refresh_cnt), 1);

        // Reset in ARB_WAIT.
        req_val = 3'b010;
        tune_phase(3'b010, 8'h22, 0, 1'b1);
        phy_commit_val = 1'b1;
        phy_pwr        = 8'h77;
        phy_code       = 8'h66;
        req_commit_rdy = '0;
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(o_grant), 0);
        check("mid_rst_commit_val", 32'(o_req_commit_val), 0);
        check("mid_rst_pwr", 32'(o_req_pwr_commit), 0);
        check("mid_rst_timeout", 32'(o_timeout), 0);
        check("mid_rst_refresh", 32'(o_phy_refresh), 0);
        phy_commit_val = 1'b0;
        phy_pwr        = '0;
        phy_code       = '0;
        tick();
        tick();
        i_rst   = 1'b0;
        req_val = 3'b111;
        tune_phase(3'b001, 8'h11, 0, 1'b1);
        commit_phase(3'b001, 0, 0, 8'h55, 8'hD5);
        check("rst_refresh_count", 32'(refresh_cnt), 1);

        // Commit on the watchdog expiry cycle wins.
        req_val = 3'b100;
        tune_phase(3'b100, 8'h33, 0, 1'b1);
        commit_phase(3'b100, WD - 1, 0, 8'h5A, 8'hA5);
        @(negedge i_clk);
        check("edge_commit_no_refresh", 32'(o_phy_refresh), 0);
        check("edge_commit_no_timeout", 32'(o_timeout), 0);
        check("edge_commit_grant_clear", 32'(o_grant), 0);
        repeat (2) @(negedge i_clk);
        check("edge_commit_refresh_count", 32'(refresh_cnt), 1);

        check("tune_q_drained", 32'(tune_q.size()), 0);
        check("commit_q_drained", 32'(commit_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tuner_ctrl_req_arbiter.md
Name: tuner_ctrl_req_arbiter

Overview:
- Shares one tuner controller-arbiter PHY between NUM_REQ high-level controllers (e.g. search, lock, dither).
- Grants PHY ownership for a whole tune→sync→commit transaction and routes tune codes downstream and commit data back to the owner.
- Round-robin fairness, optional ownership hold, and a commit watchdog that refreshes a hung PHY.
- Sits between the controllers and the PHY's tune/commit handshake ports.

Parameters:
- NUM_REQ, 3, number of requesting controllers (2..8).
- DAC_WIDTH, 8, tune code width.
- ADC_WIDTH, 8, detected power width.
- HOLD_MAX, 16, max back-to-back transactions for one holder while others wait.
- WDOG_CYCLES, 255, cycles allowed in ARB_WAIT before timeout (≥2).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_req_tune_val  in  NUM_REQ  per-requester tune request valid
- o_req_tune_rdy  out  NUM_REQ  per-requester tune accept
- i_req_ring_tune  in  NUM_REQ*DAC_WIDTH  packed tune codes, requester k at [k*DAC_WIDTH +: DAC_WIDTH]
- i_req_hold  in  NUM_REQ  keep ownership after commit
- o_req_commit_val  out  NUM_REQ  commit valid to owner only
- i_req_commit_rdy  in  NUM_REQ  commit accept
- o_req_pwr_commit  out  ADC_WIDTH  committed power, broadcast
- o_req_ring_tune_commit  out  DAC_WIDTH  committed tune code, broadcast
- o_grant  out  NUM_REQ  one-hot current owner, 0 when none
- o_phy_tune_val  out  1  to PHY
- i_phy_tune_rdy  in  1  from PHY
- o_phy_ring_tune  out  DAC_WIDTH  to PHY
- i_phy_commit_val  in  1  from PHY
- o_phy_commit_rdy  out  1  to PHY
- i_phy_pwr_commit  in  ADC_WIDTH  from PHY
- i_phy_ring_tune_commit  in  DAC_WIDTH  from PHY
- o_phy_refresh  out  1  one-cycle PHY refresh pulse
- o_timeout  out  1  sticky timeout flag; cleared by reset only

Behaviour:
- Reset: i_rst is asynchronous, active-high; clock is i_clk. On reset: state ARB_IDLE, o_grant=0, rr pointer=NUM_REQ-1, hold_cnt=0, wdog=0, every output 0.
- Fire definitions:
  - tune_fire = o_phy_tune_val && i_phy_tune_rdy.
  - commit_fire = i_phy_commit_val && i_req_commit_rdy[owner].
- ARB_IDLE: if any i_req_tune_val, register the owner as the first set bit scanning from rr_ptr+1 with wrap. Set o_grant, rr_ptr=owner, hold_cnt=0, go to ARB_TUNE. Grant latency is 1 cycle. No val: stay.
- ARB_TUNE:
  - o_phy_tune_val = i_req_tune_val[owner].
  - o_phy_ring_tune = owner's code.
  - o_req_tune_rdy[owner] = i_phy_tune_rdy; all other rdy bits 0.
  - On tune_fire go to ARB_WAIT and clear wdog.
- ARB_WAIT:
  - o_req_commit_val[owner] = i_phy_commit_val.
  - o_phy_commit_rdy = i_req_commit_rdy[owner].
  - Commit data passes through combinationally.
  - wdog increments each cycle.
  - On commit_fire:
    - If i_req_hold[owner] && (hold_cnt < HOLD_MAX-1 || no other val): go to ARB_TUNE with same owner and hold_cnt+1 (saturating).
    - Otherwise go to ARB_IDLE and o_grant=0.
  - If wdog == WDOG_CYCLES-1 without commit_fire: pulse o_phy_refresh for 1 cycle, set o_timeout, go to ARB_IDLE with o_grant=0. rr_ptr keeps the hung owner, so it has lowest priority next round.
- Non-owner rdy/commit_val are always 0. Non-owner tune data is ignored.
- A requester dropping val in ARB_TUNE is legal only if it is a holder. The arbiter waits, with the watchdog inactive in ARB_TUNE.
- Simultaneous commit_fire and watchdog expiry: commit wins, no refresh.
- Mid-transaction reset: immediate return to reset values; no refresh pulse is emitted.
- Single requester: re-granted every transaction; one idle cycle between transactions when not holding.

Decomposition:
- Shared package tuner_phy_pkg gets:
  - Typedef tuner_req_arb_state_e {ARB_IDLE, ARB_TUNE, ARB_WAIT}.
  - Constants for default requester indices (REQ_SEARCH=0, REQ_LOCK=1, REQ_DITHER=2).
- Sub-module: tuner_rr_pick, a combinational round-robin selector taking request vector and pointer, returning a one-hot winner plus a valid flag. It is reusable and tested standalone.

Test Plan:
- Req0 and req2 val together from reset (ptr=2) → grant req0 first (ptr+1=0). After its commit, grant req2; o_grant=3'b001 then 3'b100.
- Req1 code 8'hA5 granted, PHY rdy delayed 3 cycles → o_phy_ring_tune=A5. o_req_tune_rdy=3'b010 only while in ARB_TUNE; one tune_fire.
- Req1 hold=1, req0 waiting, HOLD_MAX=4 → exactly 4 consecutive req1 transactions, then req0 granted.
- PHY never asserts commit_val, WDOG_CYCLES=10 → o_phy_refresh pulses 1 cycle, 10 cycles after tune_fire. o_timeout=1 and stays 1; arbiter returns to ARB_IDLE.
- Commit pwr 8'h3C, code 8'h42, owner rdy low 5 cycles → o_phy_commit_rdy stays 0 until owner rdy; data delivered unchanged; the other requesters' commit_val stays 0.
- Assert i_rst in ARB_WAIT → all outputs 0 asynchronously. After release the next grant follows ptr=NUM_REQ-1.
